// File: rtl/lcd_pkg.sv
// lcd_pkg: RGB565 colour constants, pattern selector and colour helpers shared by
// the LCD pixel path.
package lcd_pkg;

    localparam int unsigned PIX_W = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [PIX_W-1:0] C_WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] C_YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] C_CYAN    = 16'h07FF;
    localparam logic [PIX_W-1:0] C_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] C_MAGENTA = 16'hF81F;
    localparam logic [PIX_W-1:0] C_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] C_BLUE    = 16'h001F;
    localparam logic [PIX_W-1:0] C_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GRAD  = 2'd3
    } pattern_e;

    function automatic logic [PIX_W-1:0] rgb565(input logic [4:0] r,
                                                input logic [5:0] g,
                                                input logic [4:0] b);
        return {r, g, b};
    endfunction

    // Classic eight-bar test sequence, left to right.
    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        logic [PIX_W-1:0] c;
        case (idx)
            3'd0:    c = C_WHITE;
            3'd1:    c = C_YELLOW;
            3'd2:    c = C_CYAN;
            3'd3:    c = C_GREEN;
            3'd4:    c = C_MAGENTA;
            3'd5:    c = C_RED;
            3'd6:    c = C_BLUE;
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_pattern_src.sv
// lcd_pattern_src: waits for driver init, programs a full-screen window, then streams
// RGB565 test patterns over a valid/ready pixel interface.
module lcd_pattern_src
    import lcd_pkg::*;
#(
    parameter int unsigned X_RES      = 240,
    parameter int unsigned Y_RES      = 320,
    parameter int unsigned CHK_LOG2   = 4,
    parameter int unsigned CONTINUOUS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    input  logic [PIX_W-1:0] solid_color,
    input  logic             init_done,
    input  logic             drv_busy,
    output logic             win_set_stb,
    output logic [CNT_W-1:0] win_x0,
    output logic [CNT_W-1:0] win_y0,
    output logic [CNT_W-1:0] win_x1,
    output logic [CNT_W-1:0] win_y1,
    output logic             stream_start,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(X_RES - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(Y_RES - 1);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(X_RES / 8 - 1);
    localparam bit               CONT     = (CONTINUOUS != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_WIN,
        S_WAIT_WIN,
        S_START,
        S_STREAM,
        S_FRAME_END
    } state_e;

    state_e           r_state;
    logic             r_en_d;
    logic             r_armed;
    logic             r_wait_first;
    pattern_e         r_pat;
    logic [PIX_W-1:0] r_color;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] r_bar_cnt;
    logic [2:0]       r_bar;
    logic             r_win_set_stb;
    logic             r_stream_start;
    logic [PIX_W-1:0] r_pix_data;
    logic             r_pix_valid;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_rise;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_last;
    logic [CNT_W-1:0] w_nx;
    logic [CNT_W-1:0] w_ny;
    logic [CNT_W-1:0] w_nbar_cnt;
    logic [2:0]       w_nbar;
    logic [PIX_W-1:0] w_pix;

    assign w_rise     = enable & ~r_en_d;
    assign w_start_ok = enable & init_done & (CONT | r_armed | w_rise);
    assign w_xfer     = r_pix_valid & pix_ready;
    assign w_last     = (r_x == X_LAST) && (r_y == Y_LAST);

    // Position and colour of the pixel to present after the next transfer (or first pixel in START).
    always_comb begin
        w_nx       = r_x + 16'd1;
        w_ny       = r_y;
        w_nbar_cnt = r_bar_cnt + 16'd1;
        w_nbar     = r_bar;
        w_pix      = C_BLACK;
        if (r_state == S_START) begin
            w_nx       = '0;
            w_ny       = '0;
            w_nbar_cnt = '0;
            w_nbar     = '0;
        end else begin
            if (r_bar_cnt == BAR_LAST) begin
                w_nbar_cnt = '0;
                w_nbar     = r_bar + 3'd1;
            end
            if (r_x == X_LAST) begin
                w_nx       = '0;
                w_ny       = r_y + 16'd1;
                w_nbar_cnt = '0;
                w_nbar     = '0;
            end
        end
        case (r_pat)
            PAT_SOLID: w_pix = r_color;
            PAT_BARS:  w_pix = bar_color(w_nbar);
            PAT_CHECK: w_pix = (w_nx[CHK_LOG2] ^ w_ny[CHK_LOG2]) ? r_color : C_BLACK;
            default:   w_pix = rgb565(w_nx[7:3], w_ny[8:3], r_frame_cnt[4:0]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_en_d         <= 1'b0;
            r_armed        <= 1'b0;
            r_wait_first   <= 1'b0;
            r_pat          <= PAT_SOLID;
            r_color        <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_bar_cnt      <= '0;
            r_bar          <= '0;
            r_win_set_stb  <= 1'b0;
            r_stream_start <= 1'b0;
            r_pix_data     <= '0;
            r_pix_valid    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_cnt    <= '0;
        end else begin
            r_en_d         <= enable;
            r_armed        <= r_armed | w_rise;
            r_win_set_stb  <= 1'b0;
            r_stream_start <= 1'b0;
            r_frame_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_armed       <= 1'b0;
                        r_state       <= S_SET_WIN;
                        r_win_set_stb <= 1'b1;
                        r_pat         <= pattern_e'(pattern_sel);
                        r_color       <= solid_color;
                    end
                end
                S_SET_WIN: begin
                    r_state      <= S_WAIT_WIN;
                    r_wait_first <= 1'b1;
                end
                // Busy may not rise until the cycle after the strobe, so skip one cycle.
                S_WAIT_WIN: begin
                    r_wait_first <= 1'b0;
                    if (!r_wait_first && !drv_busy) begin
                        r_state        <= S_START;
                        r_stream_start <= 1'b1;
                    end
                end
                S_START: begin
                    r_state     <= S_STREAM;
                    r_pix_valid <= 1'b1;
                    r_pix_data  <= w_pix;
                    r_x         <= w_nx;
                    r_y         <= w_ny;
                    r_bar_cnt   <= w_nbar_cnt;
                    r_bar       <= w_nbar;
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state      <= S_FRAME_END;
                            r_pix_valid  <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
                            r_x          <= '0;
                            r_y          <= '0;
                            r_bar_cnt    <= '0;
                            r_bar        <= '0;
                        end else begin
                            r_pix_data <= w_pix;
                            r_x        <= w_nx;
                            r_y        <= w_ny;
                            r_bar_cnt  <= w_nbar_cnt;
                            r_bar      <= w_nbar;
                        end
                    end
                end
                S_FRAME_END: begin
                    if (CONT && enable) begin
                        r_state       <= S_SET_WIN;
                        r_win_set_stb <= 1'b1;
                        r_pat         <= pattern_e'(pattern_sel);
                        r_color       <= solid_color;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign win_set_stb  = r_win_set_stb;
    assign win_x0       = '0;
    assign win_y0       = '0;
    assign win_x1       = X_LAST;
    assign win_y1       = Y_LAST;
    assign stream_start = r_stream_start;
    assign pix_data     = r_pix_data;
    assign pix_valid    = r_pix_valid;
    assign frame_done   = r_frame_done;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_lcd_pattern_src.sv
// tb_lcd_pattern_src: drives two pattern sources (one-shot and continuous) with a simple
// driver model and compares every accepted pixel against a reference pattern model.
`timescale 1ns/1ps
module tb_lcd_pattern_src;

    localparam int XR   = 16;
    localparam int YR   = 4;
    localparam int CHK  = 1;
    localparam int NPIX = XR * YR;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic [1:0]  sel      = 2'd0;
    logic [15:0] color    = 16'h0;
    logic        init     = 1'b0;
    logic        drv_busy = 1'b0;
    logic        rdy      = 1'b0;
    logic        use_b    = 1'b0;

    logic        en_a, en_b, rdy_a, rdy_b;
    logic        a_win, a_start, a_valid, a_done;
    logic        b_win, b_start, b_valid, b_done;
    logic [15:0] a_x0, a_y0, a_x1, a_y1, a_data, a_cnt;
    logic [15:0] b_x0, b_y0, b_x1, b_y1, b_data, b_cnt;
    logic        m_win, m_start, m_valid, m_done;
    logic [15:0] m_data, m_cnt;

    assign en_a  = en & ~use_b;
    assign en_b  = en & use_b;
    assign rdy_a = rdy & ~use_b;
    assign rdy_b = rdy & use_b;
    assign m_win   = use_b ? b_win   : a_win;
    assign m_start = use_b ? b_start : a_start;
    assign m_valid = use_b ? b_valid : a_valid;
    assign m_done  = use_b ? b_done  : a_done;
    assign m_data  = use_b ? b_data  : a_data;
    assign m_cnt   = use_b ? b_cnt   : a_cnt;

    lcd_pattern_src #(.X_RES(XR), .Y_RES(YR), .CHK_LOG2(CHK), .CONTINUOUS(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .pattern_sel(sel), .solid_color(color),
        .init_done(init), .drv_busy(drv_busy), .win_set_stb(a_win),
        .win_x0(a_x0), .win_y0(a_y0), .win_x1(a_x1), .win_y1(a_y1),
        .stream_start(a_start), .pix_data(a_data), .pix_valid(a_valid), .pix_ready(rdy_a),
        .frame_done(a_done), .frame_cnt(a_cnt));

    lcd_pattern_src #(.X_RES(XR), .Y_RES(YR), .CHK_LOG2(CHK), .CONTINUOUS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .pattern_sel(sel), .solid_color(color),
        .init_done(init), .drv_busy(drv_busy), .win_set_stb(b_win),
        .win_x0(b_x0), .win_y0(b_y0), .win_x1(b_x1), .win_y1(b_y1),
        .stream_start(b_start), .pix_data(b_data), .pix_valid(b_valid), .pix_ready(rdy_b),
        .frame_done(b_done), .frame_cnt(b_cnt));

    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] q_pix[$];
    int          n_win, n_start, n_done, n_stall_err, first_cyc, last_cyc, done_cyc;
    bit          timed_out;

    // Reference pattern for the i-th pixel of a frame, f = completed frames before it.
    function automatic logic [15:0] model_pix(input int psel, input logic [15:0] c,
                                              input int i, input int f);
        int x = i % XR;
        int y = (i / XR) % YR;
        case (psel)
            0:       return c;
            1:       return BARS[x / (XR / 8)];
            2:       return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? c : 16'h0000;
            default: return 16'((((x >> 3) % 32) << 11) | (((y >> 3) % 64) << 5) | (f % 32));
        endcase
    endfunction

    task automatic apply_reset();
        en = 1'b0; rdy = 1'b0; drv_busy = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs the driver model until `frames` frame_done pulses plus a quiet tail, logging transfers.
    task automatic collect(input int frames, input int budget, input bit rnd, input int drop_at);
        int          tail = -1;
        int          busy_cnt = 0;
        bit          prev_stall = 1'b0;
        logic [15:0] prev_data = 16'h0;
        q_pix.delete();
        n_win = 0; n_start = 0; n_done = 0; n_stall_err = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1; timed_out = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) n_stall_err++;
            if (m_win)   begin n_win++; busy_cnt = 3; end
            if (m_start) n_start++;
            if (m_done)  begin n_done++; done_cyc = cyc; end
            drv_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && rdy) begin
                q_pix.push_back(m_data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (q_pix.size() == drop_at) en = 1'b0;
            end
            prev_stall = m_valid && !rdy;
            prev_data  = m_data;
            if (n_done >= frames && tail < 0) tail = 20;
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        if (tail != 0) timed_out = 1'b1;
        rdy = 1'b0; drv_busy = 1'b0;
    endtask

    task automatic test_reset();
        int wins;
        rst_n = 1'b0; en = 1'b0; init = 1'b0; rdy = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if ({a_win, a_start, a_valid, a_done} !== 4'b0) $display("FAIL reset_strobes: got %b expected 0000", {a_win, a_start, a_valid, a_done}); else n_pass++;
        n_total++; if (a_data !== 16'h0) $display("FAIL reset_pix_data: got %h expected 0000", a_data); else n_pass++;
        n_total++; if (a_cnt !== 16'h0) $display("FAIL reset_frame_cnt: got %0d expected 0", a_cnt); else n_pass++;
        n_total++; if ({b_valid, b_cnt} !== 17'h0) $display("FAIL reset_b: got %h expected 0", {b_valid, b_cnt}); else n_pass++;
        n_total++; if ({a_x0, a_y0, a_x1, a_y1} !== {16'd0, 16'd0, 16'(XR - 1), 16'(YR - 1)}) $display("FAIL window_coords: got %h expected %h", {a_x0, a_y0, a_x1, a_y1}, {16'd0, 16'd0, 16'(XR - 1), 16'(YR - 1)}); else n_pass++;
        rst_n = 1'b1;
        wins = 0;
        repeat (10) begin @(negedge clk); if (a_win || a_start) wins++; end
        n_total++; if (wins !== 0) $display("FAIL idle_disabled: got %0d strobes expected 0", wins); else n_pass++;
        en = 1'b1;
        repeat (10) begin @(negedge clk); if (a_win || a_start) wins++; end
        n_total++; if (wins !== 0) $display("FAIL idle_no_init: got %0d strobes expected 0", wins); else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_solid();
        apply_reset();
        use_b = 1'b0; sel = 2'd0; color = 16'hF800; init = 1'b1; en = 1'b1;
        collect(1, 600, 1'b0, -1);
        n_total++; if (timed_out) $display("FAIL solid_timeout: got %0d frames expected 1", n_done); else n_pass++;
        n_total++; if (n_win !== 1 || n_start !== 1) $display("FAIL solid_strobes: got win=%0d start=%0d expected 1/1", n_win, n_start); else n_pass++;
        n_total++; if (q_pix.size() !== NPIX) $display("FAIL solid_count: got %0d expected %0d", q_pix.size(), NPIX); else n_pass++;
        foreach (q_pix[i]) begin
            n_total++; if (q_pix[i] !== model_pix(0, 16'hF800, i, 0)) $display("FAIL solid_pix[%0d]: got %h expected %h", i, q_pix[i], model_pix(0, 16'hF800, i, 0)); else n_pass++;
        end
        n_total++; if (last_cyc - first_cyc !== NPIX - 1) $display("FAIL solid_rate: got span %0d expected %0d", last_cyc - first_cyc, NPIX - 1); else n_pass++;
        n_total++; if (n_done !== 1 || done_cyc !== last_cyc + 1) $display("FAIL solid_done: got n=%0d at %0d expected 1 at %0d", n_done, done_cyc, last_cyc + 1); else n_pass++;
        n_total++; if (m_cnt !== 16'd1 || m_valid !== 1'b0) $display("FAIL solid_end: got cnt=%0d valid=%b expected 1/0", m_cnt, m_valid); else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_bars_stall();
        apply_reset();
        use_b = 1'b0; sel = 2'd1; color = 16'($urandom); init = 1'b1; en = 1'b1;
        collect(1, 1000, 1'b1, -1);
        n_total++; if (timed_out) $display("FAIL bars_timeout: got %0d frames expected 1", n_done); else n_pass++;
        n_total++; if (q_pix.size() !== NPIX) $display("FAIL bars_count: got %0d expected %0d", q_pix.size(), NPIX); else n_pass++;
        n_total++; if (n_stall_err !== 0) $display("FAIL bars_stall_stable: got %0d changes expected 0", n_stall_err); else n_pass++;
        foreach (q_pix[i]) begin
            n_total++; if (q_pix[i] !== model_pix(1, color, i, 0)) $display("FAIL bars_pix[%0d]: got %h expected %h", i, q_pix[i], model_pix(1, color, i, 0)); else n_pass++;
        end
        n_total++; if (n_done !== 1 || m_cnt !== 16'd1) $display("FAIL bars_done: got n=%0d cnt=%0d expected 1/1", n_done, m_cnt); else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_checker();
        apply_reset();
        use_b = 1'b0; sel = 2'd2; color = 16'h07E0; init = 1'b1; en = 1'b1;
        collect(1, 600, 1'b0, -1);
        n_total++; if (timed_out || q_pix.size() !== NPIX) $display("FAIL check_count: got %0d expected %0d", q_pix.size(), NPIX); else n_pass++;
        foreach (q_pix[i]) begin
            n_total++; if (q_pix[i] !== model_pix(2, 16'h07E0, i, 0)) $display("FAIL check_pix[%0d]: got %h expected %h", i, q_pix[i], model_pix(2, 16'h07E0, i, 0)); else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_continuous();
        apply_reset();
        use_b = 1'b1; sel = 2'd3; color = 16'h1234; init = 1'b1; en = 1'b1;
        collect(2, 1500, 1'b1, NPIX + 20);
        n_total++; if (timed_out) $display("FAIL cont_timeout: got %0d frames expected 2", n_done); else n_pass++;
        n_total++; if (n_win !== 2 || n_start !== 2 || n_done !== 2) $display("FAIL cont_strobes: got win=%0d start=%0d done=%0d expected 2/2/2", n_win, n_start, n_done); else n_pass++;
        n_total++; if (q_pix.size() !== 2 * NPIX) $display("FAIL cont_count: got %0d expected %0d", q_pix.size(), 2 * NPIX); else n_pass++;
        n_total++; if (n_stall_err !== 0) $display("FAIL cont_stall_stable: got %0d changes expected 0", n_stall_err); else n_pass++;
        foreach (q_pix[i]) begin
            n_total++; if (q_pix[i] !== model_pix(3, color, i, i / NPIX)) $display("FAIL grad_pix[%0d]: got %h expected %h", i, q_pix[i], model_pix(3, color, i, i / NPIX)); else n_pass++;
        end
        n_total++; if (m_cnt !== 16'd2 || m_valid !== 1'b0) $display("FAIL cont_end: got cnt=%0d valid=%b expected 2/0", m_cnt, m_valid); else n_pass++;
        use_b = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int cnt = 0;
        bit ok  = 1'b0;
        apply_reset();
        use_b = 1'b0; sel = 2'd0; color = 16'h001F; init = 1'b1; en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            rdy = 1'b1;
            if (a_valid) cnt++;
            if (cnt == 10) begin ok = 1'b1; break; end
        end
        n_total++; if (!ok) $display("FAIL midrst_reach: got %0d pixels expected 10", cnt); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++; if (a_valid !== 1'b0 || a_data !== 16'h0 || a_cnt !== 16'h0) $display("FAIL midrst_abort: got valid=%b data=%h cnt=%0d expected 0/0000/0", a_valid, a_data, a_cnt); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (a_valid !== 1'b0) $display("FAIL midrst_hold: got valid=%b expected 0", a_valid); else n_pass++;
        rst_n = 1'b1; color = 16'h07FF;
        collect(1, 600, 1'b0, -1);
        n_total++; if (timed_out || n_win !== 1 || q_pix.size() !== NPIX) $display("FAIL midrst_rerun: got win=%0d pixels=%0d expected 1/%0d", n_win, q_pix.size(), NPIX); else n_pass++;
        foreach (q_pix[i]) begin
            n_total++; if (q_pix[i] !== 16'h07FF) $display("FAIL midrst_pix[%0d]: got %h expected 07ff", i, q_pix[i]); else n_pass++;
        end
        n_total++; if (a_cnt !== 16'd1) $display("FAIL midrst_cnt: got %0d expected 1", a_cnt); else n_pass++;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_solid();
        test_bars_stall();
        test_checker();
        test_continuous();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
